// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game director.
//   game_state_e      FSM state encoding (also driven out on the 'state' port)
//   TYPE_*            enemy type indices into kill/spawn_req/spawn_ack/type_en
//   type_en_for_wave  which enemy types a given wave may spawn
//   popcount3         number of set bits in a 3-bit kill vector
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAVE_INTRO = 3'd1,
    ST_ACTIVE     = 3'd2,
    ST_HIT        = 3'd3,
    ST_WAVE_CLEAR = 3'd4,
    ST_GAMEOVER   = 3'd5
  } game_state_e;

  localparam int unsigned NUM_TYPES = 3;
  localparam logic [1:0]  TYPE_VERT = 2'd0;
  localparam logic [1:0]  TYPE_INV2 = 2'd1;
  localparam logic [1:0]  TYPE_INV3 = 2'd2;

  // Wave 0 has only the vertical enemy, waves 1-2 add inv2, wave 3 and up add inv3.
  function automatic logic [NUM_TYPES-1:0] type_en_for_wave(input logic [3:0] wave_num);
    logic [NUM_TYPES-1:0] en;
    en            = '0;
    en[TYPE_VERT] = 1'b1;
    if (wave_num >= 4'd1) en[TYPE_INV2] = 1'b1;
    if (wave_num >= 4'd3) en[TYPE_INV3] = 1'b1;
    return en;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/spawn_rr_arbiter.sv
// spawn_rr_arbiter: picks the next enabled enemy type at or after rr_ptr and
// raises a one-hot spawn request once the spawn gap has elapsed.
// Purely combinational; the pointer and gap counter live in the director.
// Ports:
//   active      in  1  spawner allowed (ACTIVE state and quota not yet spawned)
//   gap_cnt     in  8  ticks elapsed since the last accepted spawn
//   type_en     in  3  enemy types enabled for this wave
//   rr_ptr      in  2  round-robin start position (0..2)
//   spawn_ack   in  3  per-type acceptance
//   spawn_req   out 3  one-hot request
//   granted     out 1  the outstanding request was acked this clk
//   rr_ptr_next out 2  pointer value to load on grant (granted type + 1 mod 3)
module spawn_rr_arbiter
  import game_pkg::*;
#(
  parameter int unsigned SPAWN_GAP = 8
) (
  input  logic       active,
  input  logic [7:0] gap_cnt,
  input  logic [2:0] type_en,
  input  logic [1:0] rr_ptr,
  input  logic [2:0] spawn_ack,
  output logic [2:0] spawn_req,
  output logic       granted,
  output logic [1:0] rr_ptr_next
);

  logic [1:0] sel;
  logic       found;
  logic [2:0] cand;

  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(NUM_TYPES); i++) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && type_en[cand[1:0]]) begin
        found = 1'b1;
        sel   = cand[1:0];
      end
    end
  end

  // The request is a pure function of registered state, so it stays stable
  // (held) until an ack moves the pointer or resets the gap counter.
  assign spawn_req   = (active && found && (gap_cnt >= 8'(SPAWN_GAP))) ? (3'b001 << sel) : 3'b000;
  assign granted     = |(spawn_req & spawn_ack);
  assign rr_ptr_next = (sel == 2'd2) ? 2'd0 : sel + 2'd1;

endmodule

// File: rtl/game_director.sv
// game_director: top-level game sequencer. Owns game state, lives and wave
// progression, and schedules enemy spawns over a req/ack handshake.
// Ports:
//   clk        in  1  system clock
//   clr        in  1  asynchronous active-low reset
//   tick       in  1  one-clk timebase enable
//   play       in  1  play switch (level)
//   hit_player in  1  player hit pulse
//   kill       in  3  kill pulse per enemy type
//   spawn_ack  in  3  per-type spawn acceptance
//   spawn_req  out 3  one-hot spawn request, held until acked
//   type_en    out 3  enemy types enabled for the current wave
//   freeze     out 1  enemies hold / player invulnerable
//   lives      out 3  remaining lives
//   wave       out 4  wave number, saturating at 15
//   gameover   out 1  game over indicator
//   state      out 3  encoded FSM state
// Build option: GAME_DIRECTOR_BONUS_LIFE_EN grants one life (up to LIVES_MAX)
// on every wave clear.
//
// state       | meaning
// IDLE        | waiting for a rising edge on play
// WAVE_INTRO  | frozen intro, INTRO_TICKS ticks
// ACTIVE      | wave in play, spawner running, kills counted
// HIT         | player hit, frozen for HIT_TICKS ticks, kills still counted
// WAVE_CLEAR  | one clk, advances wave
// GAMEOVER    | out of lives, waits for play to drop
module game_director
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned LIVES_MAX   = 7,
  parameter int unsigned BASE_QUOTA  = 4,
  parameter int unsigned INTRO_TICKS = 32,
  parameter int unsigned HIT_TICKS   = 16,
  parameter int unsigned SPAWN_GAP   = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       play,
  input  logic       hit_player,
  input  logic [2:0] kill,
  input  logic [2:0] spawn_ack,
  output logic [2:0] spawn_req,
  output logic [2:0] type_en,
  output logic       freeze,
  output logic [2:0] lives,
  output logic [3:0] wave,
  output logic       gameover,
  output logic [2:0] state
);

`ifdef GAME_DIRECTOR_BONUS_LIFE_EN
  localparam bit BONUS_LIFE = 1'b1;
`else
  localparam bit BONUS_LIFE = 1'b0;
`endif

  game_state_e state_q, state_d;
  logic       play_q;
  logic [2:0] lives_q, lives_d;
  logic [3:0] wave_q, wave_d;
  logic [5:0] kill_cnt_q, kill_cnt_d;
  logic [5:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic       start;
  logic [5:0] quota;
  logic [6:0] kill_sum;
  logic [5:0] kill_cnt_sat;
  logic       quota_met;
  logic       spawner_active;
  logic       granted;
  logic [1:0] rr_ptr_next;

  assign start        = play & ~play_q;
  assign quota        = 6'(BASE_QUOTA) + {1'b0, wave_q, 1'b0};
  assign kill_sum     = {1'b0, kill_cnt_q} + 7'(popcount3(kill));
  assign kill_cnt_sat = (kill_sum > 7'd63) ? 6'd63 : kill_sum[5:0];
  // Includes this clk's kills so a simultaneous final kill is not lost.
  assign quota_met    = (kill_sum >= {1'b0, quota});

  assign spawner_active = (state_q == ST_ACTIVE) && (spawn_cnt_q < quota);

  spawn_rr_arbiter #(
    .SPAWN_GAP (SPAWN_GAP)
  ) u_arb (
    .active      (spawner_active),
    .gap_cnt     (gap_cnt_q),
    .type_en     (type_en),
    .rr_ptr      (rr_ptr_q),
    .spawn_ack   (spawn_ack),
    .spawn_req   (spawn_req),
    .granted     (granted),
    .rr_ptr_next (rr_ptr_next)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    wave_d      = wave_q;
    kill_cnt_d  = kill_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rr_ptr_d    = rr_ptr_q;

    if (state_q == ST_ACTIVE || state_q == ST_HIT) kill_cnt_d = kill_cnt_sat;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WAVE_INTRO;
          lives_d     = 3'(LIVES_INIT);
          wave_d      = 4'd0;
          kill_cnt_d  = '0;
          spawn_cnt_d = '0;
          tick_cnt_d  = '0;
          gap_cnt_d   = '0;
          rr_ptr_d    = '0;
        end
      end
      ST_WAVE_INTRO: begin
        if (tick) begin
          if (tick_cnt_q == 8'(INTRO_TICKS - 1)) begin
            state_d     = ST_ACTIVE;
            tick_cnt_d  = '0;
            kill_cnt_d  = '0;
            spawn_cnt_d = '0;
            gap_cnt_d   = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      ST_ACTIVE: begin
        if (tick && gap_cnt_q < 8'(SPAWN_GAP)) gap_cnt_d = gap_cnt_q + 8'd1;
        if (granted) begin
          spawn_cnt_d = spawn_cnt_q + 6'd1;
          rr_ptr_d    = rr_ptr_next;
          gap_cnt_d   = '0;
        end
        if (hit_player) begin
          state_d    = ST_HIT;
          lives_d    = lives_q - 3'd1;
          tick_cnt_d = '0;
        end else if (quota_met) begin
          state_d = ST_WAVE_CLEAR;
        end
      end
      ST_HIT: begin
        if (lives_q == 3'd0) begin
          state_d = ST_GAMEOVER;
        end else if (tick) begin
          if (tick_cnt_q == 8'(HIT_TICKS - 1)) begin
            tick_cnt_d = '0;
            // A wave whose quota was finished during the hit clears directly.
            state_d    = quota_met ? ST_WAVE_CLEAR : ST_ACTIVE;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      ST_WAVE_CLEAR: begin
        state_d    = ST_WAVE_INTRO;
        tick_cnt_d = '0;
        wave_d     = (wave_q == 4'd15) ? 4'd15 : wave_q + 4'd1;
        if (BONUS_LIFE && lives_q < 3'(LIVES_MAX)) lives_d = lives_q + 3'd1;
      end
      ST_GAMEOVER: begin
        if (!play) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!play && state_q != ST_IDLE && state_q != ST_GAMEOVER) begin
      state_d     = ST_IDLE;
      kill_cnt_d  = '0;
      spawn_cnt_d = '0;
      tick_cnt_d  = '0;
      gap_cnt_d   = '0;
      rr_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      play_q      <= 1'b0;
      lives_q     <= 3'(LIVES_INIT);
      wave_q      <= '0;
      kill_cnt_q  <= '0;
      spawn_cnt_q <= '0;
      tick_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      play_q      <= play;
      lives_q     <= lives_d;
      wave_q      <= wave_d;
      kill_cnt_q  <= kill_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign type_en  = (state_q == ST_IDLE || state_q == ST_GAMEOVER) ? 3'b000 : type_en_for_wave(wave_q);
  assign freeze   = (state_q == ST_WAVE_INTRO) || (state_q == ST_HIT);
  assign gameover = (state_q == ST_GAMEOVER);
  assign lives    = lives_q;
  assign wave     = wave_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_director.sv
module tb_game_director;

  localparam int S_IDLE = 0, S_INTRO = 1, S_ACTIVE = 2, S_HIT = 3, S_CLEAR = 4, S_OVER = 5;
  localparam int INTRO_T = 32, HIT_T = 16, GAP_T = 8, L_INIT = 3, L_MAX = 7;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic       play = 1'b0;
  logic       hit_player = 1'b0;
  logic [2:0] kill = 3'b000;
  logic [2:0] spawn_ack = 3'b000;
  logic [2:0] spawn_req, type_en, lives, state;
  logic       freeze, gameover;
  logic [3:0] wave;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr, m_wave, m_lives;

  always #5 clk = ~clk;

  game_director dut (
    .clk(clk), .clr(clr), .tick(tick), .play(play), .hit_player(hit_player),
    .kill(kill), .spawn_ack(spawn_ack), .spawn_req(spawn_req), .type_en(type_en),
    .freeze(freeze), .lives(lives), .wave(wave), .gameover(gameover), .state(state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_type_en(input int w);
    if (w == 0) return 3'b001;
    if (w <= 2) return 3'b011;
    return 3'b111;
  endfunction

  function automatic int quota(input int w);
    return 4 + 2 * w;
  endfunction

  function automatic int pop3(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  function automatic int first_enabled(input logic [2:0] mask, input int ptr);
    logic [2:0] m;
    m = mask;
    for (int i = 0; i < 3; i++) if (m[(ptr + i) % 3]) return (ptr + i) % 3;
    return -1;
  endfunction

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  task automatic start_game();
    play = 1'b0;
    cyc();
    play = 1'b1;
    cyc();
    m_ptr = 0; m_wave = 0; m_lives = L_INIT;
    check("start_state", 32'(state), S_INTRO);
    check("start_lives", 32'(lives), 32'(m_lives));
    check("start_wave", 32'(wave), 0);
    check("start_freeze", 32'(freeze), 1);
  endtask

  task automatic enter_active();
    ticks(INTRO_T - 1);
    check("intro_hold", 32'(state), S_INTRO);
    ticks(1);
    check("intro_done", 32'(state), S_ACTIVE);
    check("active_freeze", 32'(freeze), 0);
  endtask

  task automatic do_spawn();
    int t;
    logic [2:0] r;
    t = first_enabled(exp_type_en(m_wave), m_ptr);
    r = 3'b001 << t;
    ticks(GAP_T - 1);
    check("gap_not_elapsed", 32'(spawn_req), 0);
    ticks(1);
    check("spawn_req", 32'(spawn_req), 32'(r));
    repeat ($urandom_range(1, 4)) cyc();
    spawn_ack = ~r;
    cyc();
    spawn_ack = 3'b000;
    check("spawn_held", 32'(spawn_req), 32'(r));
    spawn_ack = r;
    cyc();
    spawn_ack = 3'b000;
    check("spawn_acked", 32'(spawn_req), 0);
    m_ptr = (t + 1) % 3;
  endtask

  task automatic wave_cleared();
    m_wave = (m_wave < 15) ? m_wave + 1 : 15;
`ifdef GAME_DIRECTOR_BONUS_LIFE_EN
    if (m_lives < L_MAX) m_lives = m_lives + 1;
`endif
    cyc();
    check("next_intro", 32'(state), S_INTRO);
    check("next_wave", 32'(wave), 32'(m_wave));
    check("next_type_en", 32'(type_en), 32'(exp_type_en(m_wave)));
    check("clear_lives", 32'(lives), 32'(m_lives));
  endtask

  task automatic clear_by_kills();
    int total;
    logic [2:0] v;
    total = 0;
    for (int i = 0; i < 40 && total < quota(m_wave); i++) begin
      v = 3'($urandom_range(1, 7));
      kill = v;
      cyc();
      kill = 3'b000;
      total += pop3(v);
      check("kill_progress", 32'(state), (total >= quota(m_wave)) ? S_CLEAR : S_ACTIVE);
    end
    wave_cleared();
  endtask

  task automatic hit_and_recover();
    hit_player = 1'b1;
    cyc();
    hit_player = 1'b0;
    m_lives--;
    check("hit_state", 32'(state), S_HIT);
    check("hit_lives", 32'(lives), 32'(m_lives));
    check("hit_freeze", 32'(freeze), 1);
    check("hit_req_drop", 32'(spawn_req), 0);
    if (m_lives > 0) begin
      hit_player = 1'b1;
      cyc();
      hit_player = 1'b0;
      check("hit_ignored", 32'(lives), 32'(m_lives));
      ticks(HIT_T - 1);
      check("hit_hold", 32'(state), S_HIT);
      ticks(1);
      check("hit_exit", 32'(state), S_ACTIVE);
    end else begin
      cyc();
      check("gameover_state", 32'(state), S_OVER);
      check("gameover_flag", 32'(gameover), 1);
      check("gameover_type_en", 32'(type_en), 0);
    end
  endtask

  initial begin
    // reset with play held high
    clr = 1'b0; play = 1'b1;
    repeat (3) cyc();
    check("rst_state", 32'(state), S_IDLE);
    check("rst_lives", 32'(lives), L_INIT);
    check("rst_wave", 32'(wave), 0);
    check("rst_req", 32'(spawn_req), 0);
    check("rst_type_en", 32'(type_en), 0);
    check("rst_freeze", 32'(freeze), 0);
    check("rst_gameover", 32'(gameover), 0);
    play = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();
    check("idle_after_rst", 32'(state), S_IDLE);

    // first spawns of wave 0: only type 0
    start_game();
    check("w0_type_en", 32'(type_en), 32'(exp_type_en(0)));
    enter_active();
    do_spawn();
    do_spawn();

    // clear wave 0 by kills, then wave 1 spawns alternate
    start_game();
    enter_active();
    clear_by_kills();
    enter_active();
    for (int i = 0; i < 4; i++) do_spawn();

    // hits until game over
    while (m_lives > 0) hit_and_recover();
    play = 1'b0;
    cyc();
    check("over_to_idle", 32'(state), S_IDLE);

    // hit together with final kill
    start_game();
    enter_active();
    for (int i = 0; i < quota(0) - 1; i++) begin
      kill = 3'b001;
      cyc();
      kill = 3'b000;
      check("pre_kill", 32'(state), S_ACTIVE);
    end
    kill = 3'b001; hit_player = 1'b1;
    cyc();
    kill = 3'b000; hit_player = 1'b0;
    m_lives--;
    check("tie_hit_state", 32'(state), S_HIT);
    check("tie_hit_lives", 32'(lives), 32'(m_lives));
    ticks(HIT_T);
    check("tie_to_clear", 32'(state), S_CLEAR);
    wave_cleared();

    // drop play with a pending request
    enter_active();
    ticks(GAP_T);
    check("pending_req", 32'(spawn_req), 32'(3'b001 << first_enabled(exp_type_en(m_wave), 0)));
    play = 1'b0;
    cyc();
    check("abort_state", 32'(state), S_IDLE);
    check("abort_req", 32'(spawn_req), 0);
    check("abort_type_en", 32'(type_en), 0);

    // wave saturation over many cleared waves
    start_game();
    for (int w = 0; w < 17; w++) begin
      enter_active();
      clear_by_kills();
    end
    check("wave_saturated", 32'(wave), 15);

    // asynchronous reset mid-game
    ticks(5);
    #2 clr = 1'b0;
    #1;
    check("async_rst_state", 32'(state), S_IDLE);
    check("async_rst_lives", 32'(lives), L_INIT);
    check("async_rst_wave", 32'(wave), 0);
    check("async_rst_freeze", 32'(freeze), 0);
    play = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();
    check("post_rst_idle", 32'(state), S_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
